ahb_mem_slave: RTL and testbench

//  Parametrised AHB-lite slave bridging the bus to a single-port synchronous memory.
//  - Pipelines address and data phases.
//  - Inserts wait states for memory read latency.
//  - Generates byte enables from HSize and the low address bits.
//  - Returns the two-cycle AHB ERROR response for out-of-range, misaligned or oversize transfers.

---
 rtl/ahb_mem_slave.sv | 172 +++++++++++++++++
 tb/tb_ahb_mem_slave.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_slave.sv
// AHB-lite slave in front of a single-port synchronous SRAM: pipelined address/data
// phases, read wait states, byte-lane generation and the two-cycle ERROR response.
module ahb_mem_slave #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_AW     = 18,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  HSel,
    input  logic [1:0]            HTrans,
    input  logic [ADDR_W-1:0]     HAddress,
    input  logic                  HWrite,
    input  logic [2:0]            HSize,
    input  logic                  HReadyIn,
    input  logic [DATA_W-1:0]     HWrite_data,
    output logic [DATA_W-1:0]     HRead_data,
    output logic                  HReady,
    output logic [1:0]            HResp,
    output logic [ADDR_W-1:0]     MAddress,
    output logic [DATA_W-1:0]     MWrite_data,
    output logic [DATA_W/8-1:0]   MByteEn,
    output logic                  Mwrite,
    output logic                  Menable,
    input  logic [DATA_W-1:0]     MRead_data
);

    localparam int BE_W  = DATA_W / 8;
    localparam int BEA_W = $clog2(BE_W);
    localparam int CNT_W = (MEM_RD_LAT > 0) ? $clog2(MEM_RD_LAT + 1) : 1;

    localparam logic [1:0]       RESP_OKAY    = 2'b00;
    localparam logic [1:0]       RESP_ERROR   = 2'b01;
    localparam logic             RD_ZERO_WAIT = (MEM_RD_LAT == 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] RD_LAT_LOAD  = CNT_W'(MEM_RD_LAT);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Lane mask for the transfer size, moved up to the addressed byte.
    function automatic logic [BE_W-1:0] byte_en(input logic [2:0] size, input logic [BEA_W-1:0] lo);
        logic [7:0] m;
        case (size)
            3'd0:    m = 8'h01;
            3'd1:    m = 8'h03;
            3'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m[BE_W-1:0] << lo;
    endfunction

    // Out-of-range, misaligned or wider-than-bus transfers are refused.
    function automatic logic xfer_err(input logic [ADDR_W-1:0] a, input logic [2:0] size);
        logic [10:0] bits;
        logic        bad;
        bits = 11'd8 << size;
        bad  = |a[ADDR_W-1:MEM_AW];
        case (size)
            3'd0:    bad = bad;
            3'd1:    bad = bad | a[0];
            3'd2:    bad = bad | (|a[1:0]);
            3'd3:    bad = bad | (|a[2:0]);
            default: bad = 1'b1;
        endcase
        if (bits > 11'(DATA_W)) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                hready_r;
    logic [1:0]          hresp_r;
    logic                menable_r;
    logic                mwrite_r;
    logic [BE_W-1:0]     mbe_r;
    logic [ADDR_W-1:0]   maddr_r;

    logic                accept_s;
    logic                err_s;
    logic [BE_W-1:0]     be_s;
    logic                unused_s;

    assign accept_s = HSel & HTrans[1] & HReadyIn & hready_r;
    assign err_s    = xfer_err(HAddress, HSize);
    assign be_s     = byte_en(HSize, HAddress[BEA_W-1:0]);
    assign unused_s = HTrans[0];

    // Write data and read data only exist in the data phase, so they pass straight through.
    assign MWrite_data = (state_r == ST_WR) ? HWrite_data : {DATA_W{1'b0}};
    assign HRead_data  = ((state_r == ST_RD) && (cnt_r == {CNT_W{1'b0}})) ? MRead_data : {DATA_W{1'b0}};

    assign HReady   = hready_r;
    assign HResp    = hresp_r;
    assign Menable  = menable_r;
    assign Mwrite   = mwrite_r;
    assign MByteEn  = mbe_r;
    assign MAddress = maddr_r;

    // Transfer FSM: accepts an address phase whenever the current data phase completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            hready_r  <= 1'b1;
            hresp_r   <= RESP_OKAY;
            menable_r <= 1'b0;
            mwrite_r  <= 1'b0;
            mbe_r     <= {BE_W{1'b0}};
            maddr_r   <= {ADDR_W{1'b0}};
        end else if (hready_r) begin
            if (accept_s && err_s) begin
                state_r   <= ST_ERR1;
                hready_r  <= 1'b0;
                hresp_r   <= RESP_ERROR;
                menable_r <= 1'b0;
                mwrite_r  <= 1'b0;
                mbe_r     <= {BE_W{1'b0}};
            end else if (accept_s) begin
                maddr_r   <= {{(ADDR_W-MEM_AW){1'b0}}, HAddress[MEM_AW-1:0]};
                mbe_r     <= be_s;
                menable_r <= 1'b1;
                mwrite_r  <= HWrite;
                hresp_r   <= RESP_OKAY;
                if (HWrite) begin
                    state_r  <= ST_WR;
                    hready_r <= 1'b1;
                end else begin
                    state_r  <= ST_RD;
                    cnt_r    <= RD_LAT_LOAD;
                    hready_r <= RD_ZERO_WAIT;
                end
            end else begin
                state_r   <= ST_IDLE;
                hready_r  <= 1'b1;
                hresp_r   <= RESP_OKAY;
                menable_r <= 1'b0;
                mwrite_r  <= 1'b0;
                mbe_r     <= {BE_W{1'b0}};
            end
        end else begin
            // Wait cycles never touch the memory.
            menable_r <= 1'b0;
            mwrite_r  <= 1'b0;
            mbe_r     <= {BE_W{1'b0}};
            case (state_r)
                ST_RD: begin
                    cnt_r    <= cnt_r - CNT_W'(1);
                    hready_r <= (cnt_r == CNT_W'(1));
                end
                ST_ERR1: begin
                    state_r  <= ST_ERR2;
                    hready_r <= 1'b1;
                    hresp_r  <= RESP_ERROR;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    hready_r <= 1'b1;
                    hresp_r  <= RESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench: four slaves with MEM_RD_LAT 0..3, each behind its own SRAM model
// whose read data is valid only in the exact cycle its latency implies.
module tb_ahb_mem_slave;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel [4];
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata [4];
    logic        hready [4];
    logic [1:0]  hresp [4];
    logic [31:0] maddr [4];
    logic [31:0] mwdata [4];
    logic [31:0] mrdata [4];
    logic [3:0]  mbe [4];
    logic        mwrite [4];
    logic        menable [4];

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_slv
        logic [31:0] mem [256];
        logic [2:0]  vld;
        logic [31:0] dq [3];
        logic [7:0]  idx;
        assign idx = maddr[g][9:2];

        ahb_mem_slave #(.ADDR_W(32), .DATA_W(32), .MEM_AW(18), .MEM_RD_LAT(g)) u_dut (
            .clk(clk), .rst(rst), .HSel(hsel[g]), .HTrans(htrans), .HAddress(haddr),
            .HWrite(hwrite), .HSize(hsize), .HReadyIn(hready[g]), .HWrite_data(hwdata),
            .HRead_data(hrdata[g]), .HReady(hready[g]), .HResp(hresp[g]),
            .MAddress(maddr[g]), .MWrite_data(mwdata[g]), .MByteEn(mbe[g]),
            .Mwrite(mwrite[g]), .Menable(menable[g]), .MRead_data(mrdata[g])
        );

        always @(posedge clk) begin
            if (menable[g] && mwrite[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mbe[g][b]) mem[idx][8*b +: 8] <= mwdata[g][8*b +: 8];
                end
            end
            if (!rst) vld <= 3'b000;
            else vld <= {vld[1:0], menable[g] & ~mwrite[g]};
            dq[0] <= mem[idx];
            dq[1] <= dq[0];
            dq[2] <= dq[1];
        end

        if (g == 0) begin : g_comb
            assign mrdata[g] = mem[idx];
        end else begin : g_lat
            assign mrdata[g] = vld[g-1] ? dq[g-1] : 32'hBAD0_BAD0;
        end
    end

    task automatic bus(input int g, input logic sel, input logic [1:0] tr, input logic [31:0] a,
                       input logic w, input logic [2:0] sz, input logic [31:0] wd);
        @(negedge clk);
        for (int i = 0; i < 4; i++) hsel[i] = 1'b0;
        hsel[g] = sel;
        htrans  = tr;
        haddr   = a;
        hwrite  = w;
        hsize   = sz;
        hwdata  = wd;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        nchk++; if (hready[2] !== 1'b1) begin nerr++; $display("FAIL rst_hready: got %b want 1", hready[2]); end
        nchk++; if (hresp[2] !== 2'b00) begin nerr++; $display("FAIL rst_hresp: got %b want 00", hresp[2]); end
        nchk++; if ({menable[2], mwrite[2], mbe[2]} !== 6'd0) begin nerr++; $display("FAIL rst_mem_ctl: got %b%b%h want 0", menable[2], mwrite[2], mbe[2]); end
        nchk++; if ({maddr[2], mwdata[2], hrdata[2]} !== 96'd0) begin nerr++; $display("FAIL rst_data: got %h %h %h want 0", maddr[2], mwdata[2], hrdata[2]); end
        @(negedge clk);
        rst = 1'b1;
        bus(2, 1'b1, T_NSEQ, 32'h40, 1'b0, 3'd2, 32'h0);
        bus(2, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        nchk++; if ({hready[2], menable[2]} !== 2'b01) begin nerr++; $display("FAIL rst_rd_d0: got hready=%b menable=%b want 0 1", hready[2], menable[2]); end
        bus(2, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        nchk++; if ({hready[2], menable[2]} !== 2'b00) begin nerr++; $display("FAIL rst_rd_d1: got hready=%b menable=%b want 0 0", hready[2], menable[2]); end
        rst = 1'b0;
        #1;
        nchk++; if ({hready[2], hresp[2], menable[2]} !== 4'b1000) begin nerr++; $display("FAIL rst_async: got hready=%b hresp=%b menable=%b want 1 00 0", hready[2], hresp[2], menable[2]); end
        @(negedge clk);
        rst = 1'b1;
        bus(2, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        bus(2, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        nchk++; if ({hready[2], menable[2], hrdata[2]} !== {2'b10, 32'h0}) begin nerr++; $display("FAIL rst_after: got hready=%b menable=%b hrdata=%h want 1 0 0", hready[2], menable[2], hrdata[2]); end
    endtask

    task automatic test_write_read();
        bus(1, 1'b1, T_NSEQ, 32'h100, 1'b1, 3'd2, 32'h0);
        bus(1, 1'b1, T_NSEQ, 32'h100, 1'b0, 3'd2, 32'hDEAD_BEEF);
        nchk++; if ({hready[1], menable[1], mwrite[1], mbe[1]} !== 7'b111_1111) begin nerr++; $display("FAIL wr_ctl: got hready=%b menable=%b mwrite=%b mbe=%h want 1 1 1 f", hready[1], menable[1], mwrite[1], mbe[1]); end
        nchk++; if ({maddr[1], mwdata[1]} !== {32'h100, 32'hDEAD_BEEF}) begin nerr++; $display("FAIL wr_addr_data: got %h %h want 00000100 deadbeef", maddr[1], mwdata[1]); end
        bus(1, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        nchk++; if ({hready[1], menable[1], mwrite[1], hrdata[1]} !== {3'b010, 32'h0}) begin nerr++; $display("FAIL rd_wait: got hready=%b menable=%b mwrite=%b hrdata=%h want 0 1 0 0", hready[1], menable[1], mwrite[1], hrdata[1]); end
        bus(1, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        nchk++; if ({hready[1], menable[1], hrdata[1]} !== {2'b10, 32'hDEAD_BEEF}) begin nerr++; $display("FAIL rd_done: got hready=%b menable=%b hrdata=%h want 1 0 deadbeef", hready[1], menable[1], hrdata[1]); end
        bus(1, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        nchk++; if ({hready[1], hrdata[1]} !== {1'b1, 32'h0}) begin nerr++; $display("FAIL rd_idle: got hready=%b hrdata=%h want 1 0", hready[1], hrdata[1]); end
    endtask

    task automatic test_byte_lanes();
        bus(1, 1'b1, T_NSEQ, 32'h102, 1'b1, 3'd1, 32'h0);
        bus(1, 1'b1, T_NSEQ, 32'h103, 1'b1, 3'd0, 32'h1234_0000);
        nchk++; if ({menable[1], mbe[1], maddr[1]} !== {1'b1, 4'hC, 32'h102}) begin nerr++; $display("FAIL half_be: got menable=%b mbe=%h maddr=%h want 1 c 00000102", menable[1], mbe[1], maddr[1]); end
        bus(1, 1'b1, T_NSEQ, 32'h100, 1'b0, 3'd2, 32'hAA00_0000);
        nchk++; if ({menable[1], mbe[1], maddr[1]} !== {1'b1, 4'h8, 32'h103}) begin nerr++; $display("FAIL byte_be: got menable=%b mbe=%h maddr=%h want 1 8 00000103", menable[1], mbe[1], maddr[1]); end
        bus(1, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        bus(1, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        nchk++; if ({hready[1], hrdata[1]} !== {1'b1, 32'hAA34_BEEF}) begin nerr++; $display("FAIL lane_merge: got hready=%b hrdata=%h want 1 aa34beef", hready[1], hrdata[1]); end
    endtask

    task automatic test_errors();
        logic [31:0] ea [3] = '{32'h0004_0000, 32'h0000_0101, 32'h0000_0108};
        logic        ew [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  es [3] = '{3'd2, 3'd1, 3'd3};
        for (int i = 0; i < 3; i++) begin
            bus(1, 1'b1, T_NSEQ, ea[i], ew[i], es[i], 32'h0);
            bus(1, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h5555_5555);
            nchk++; if ({hready[1], hresp[1], menable[1]} !== 4'b0010) begin nerr++; $display("FAIL err1_%0d: got hready=%b hresp=%b menable=%b want 0 01 0", i, hready[1], hresp[1], menable[1]); end
            bus(1, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
            nchk++; if ({hready[1], hresp[1], menable[1]} !== 4'b1010) begin nerr++; $display("FAIL err2_%0d: got hready=%b hresp=%b menable=%b want 1 01 0", i, hready[1], hresp[1], menable[1]); end
            bus(1, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
            nchk++; if ({hready[1], hresp[1]} !== 3'b100) begin nerr++; $display("FAIL err_end_%0d: got hready=%b hresp=%b want 1 00", i, hready[1], hresp[1]); end
        end
    endtask

    task automatic test_back_to_back();
        bus(0, 1'b1, T_NSEQ, 32'h10, 1'b1, 3'd2, 32'h0);
        bus(0, 1'b1, T_SEQ, 32'h14, 1'b1, 3'd2, 32'h0A0A_0A0A);
        nchk++; if ({hready[0], menable[0], mwrite[0], maddr[0], mwdata[0]} !== {3'b111, 32'h10, 32'h0A0A_0A0A}) begin nerr++; $display("FAIL b2b_wr1: got %b%b%b %h %h want 111 00000010 0a0a0a0a", hready[0], menable[0], mwrite[0], maddr[0], mwdata[0]); end
        bus(0, 1'b1, T_NSEQ, 32'h10, 1'b0, 3'd2, 32'h0B0B_0B0B);
        nchk++; if ({hready[0], menable[0], mwrite[0], maddr[0], mwdata[0]} !== {3'b111, 32'h14, 32'h0B0B_0B0B}) begin nerr++; $display("FAIL b2b_wr2: got %b%b%b %h %h want 111 00000014 0b0b0b0b", hready[0], menable[0], mwrite[0], maddr[0], mwdata[0]); end
        bus(0, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        nchk++; if ({hready[0], menable[0], mwrite[0], hrdata[0]} !== {3'b110, 32'h0A0A_0A0A}) begin nerr++; $display("FAIL b2b_rd: got %b%b%b %h want 110 0a0a0a0a", hready[0], menable[0], mwrite[0], hrdata[0]); end
        bus(0, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        nchk++; if ({hready[0], menable[0], hrdata[0]} !== {2'b10, 32'h0}) begin nerr++; $display("FAIL b2b_idle: got %b%b %h want 10 0", hready[0], menable[0], hrdata[0]); end
    endtask

    task automatic test_lat3_and_idle();
        int          low = 0;
        int          en = 0;
        logic        done = 1'b0;
        logic [31:0] rd = 32'h0;
        logic [1:0]  tt [4] = '{T_IDLE, T_BUSY, T_NSEQ, T_IDLE};
        logic        ts [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        bus(3, 1'b1, T_NSEQ, 32'h20, 1'b1, 3'd2, 32'h0);
        bus(3, 1'b1, T_NSEQ, 32'h20, 1'b0, 3'd2, 32'hCAFE_F00D);
        for (int i = 0; i < 10 && !done; i++) begin
            bus(3, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
            if (menable[3]) en++;
            if (hready[3]) begin
                done = 1'b1;
                rd   = hrdata[3];
            end else begin
                low++;
            end
        end
        nchk++; if (done !== 1'b1) begin nerr++; $display("FAIL lat3_timeout: got no HReady within 10 cycles want done"); end
        nchk++; if (low != 3) begin nerr++; $display("FAIL lat3_waits: got %0d want 3", low); end
        nchk++; if (en != 1) begin nerr++; $display("FAIL lat3_menable: got %0d pulses want 1", en); end
        nchk++; if (rd !== 32'hCAFE_F00D) begin nerr++; $display("FAIL lat3_data: got %h want cafef00d", rd); end
        for (int i = 0; i < 4; i++) begin
            bus(3, ts[i], tt[i], 32'h24, 1'b1, 3'd2, 32'h0);
            if (i > 0) begin
                nchk++; if ({hready[3], hresp[3], menable[3], mwrite[3]} !== 5'b10000) begin nerr++; $display("FAIL idle_busy_%0d: got hready=%b hresp=%b menable=%b mwrite=%b want 1 00 0 0", i, hready[3], hresp[3], menable[3], mwrite[3]); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) hsel[i] = 1'b0;
        htrans = T_IDLE;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = 3'd0;
        hwdata = 32'h0;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_errors();
        test_back_to_back();
        test_lat3_and_idle();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
